ca_run_controller: RTL and testbench
====================================

# ca_run_controller

Sequencer for the 64-bit cellular-automaton state register. It loads a seed and runs a configurable number of elementary-CA generations, one per clock, under an 8-bit Wolfram rule. It can pause, and it signals busy/done. A 16-bit slice of the live state, chosen by a 2-bit select, drives the board LEDs. It sits between the seed-entry block, which assembles the 64-bit seed from nibble switches, and the LED/display logic.

## Interface
Parameters:
- WIDTH, 64: CA cell count. Must be a multiple of 16.
- CNT_W, 8: width of the generation counter and of `steps`.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  reset, synchronous and active-high
- start  in  1  level; sampled only in IDLE
- pause  in  1  holds RUN without stepping while high
- rule  in  8  Wolfram rule number; captured at start
- steps  in  CNT_W  generations to run; captured at start
- wrap  in  1  boundary mode: 1 = toroidal, 0 = cells outside the array read as 0; captured at start
- seed  in  WIDTH  initial state; captured at start
- select  in  2  LED slice select
- state  out  WIDTH  current CA generation (registered)
- led  out  16  equals `state[16*select +: 16]` (combinational from `state`)
- gen_count  out  CNT_W  generations completed since the last start
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse in DONE

## Operation
- FSM states: IDLE, RUN, DONE. The state enum lives in the package.
- IDLE, start=1:
  - Capture rule, steps and wrap into internal registers.
  - state <= seed; gen_count <= 0.
  - Go to RUN if steps != 0, else go to DONE.
- RUN, pause=0:
  - state <= next(state); gen_count <= gen_count+1.
  - If gen_count+1 == captured steps, go to DONE.
- RUN, pause=1: all registers hold. busy stays 1.
- DONE: done=1 for exactly one cycle, then go to IDLE. state and gen_count hold until the next start.
- start is ignored in RUN and DONE. It is not queued.
- If start is still high on returning to IDLE, a new run begins. This is intended level behaviour.
- Input changes after start have no effect on the current run. The only exception is select, which acts live.
- Next-generation rule, for each bit i:
  - Neighbourhood: L = bit i+1, C = bit i, R = bit i-1. Bit WIDTH-1 is the leftmost cell.
  - new[i] = rule[{L,C,R}].
  - Edge neighbours: bit WIDTH (i+1 off the left end) is bit 0 if wrap=1, else 0. Bit -1 (i-1 off the right end) is bit WIDTH-1 if wrap=1, else 0.
- gen_count does not wrap: its maximum is steps ≤ 2^CNT_W − 1.

## Timing
- Reset values: state=0, gen_count=0, led=0, busy=0, done=0, FSM=IDLE.
- rst mid-run aborts the run immediately. No done pulse is issued.
- Start sampled at edge E0: state=seed and busy=1 after E0.
- The k-th generation is visible after edge E0+k for k = 1..steps, with no pauses.
- DONE occupies the cycle after edge E0+steps: done=1, busy=0.
- IDLE is reached after edge E0+steps+1.
- Each cycle of pause in RUN adds one cycle of latency.
- steps=0: DONE occupies the cycle after E0, with state=seed.
- led follows state and select with zero added latency.

## Structure
- Package `ca_pkg`:
  - FSM state typedef `ca_state_t`.
  - Default WIDTH and CNT_W constants.
  - Rule-number constants used by the benches: RULE_IDENT=204, RULE_SHL=170, RULE_90=90.
- Sub-module `ca_next_gen`: purely combinational.
  - Inputs: cur[WIDTH], rule[8], wrap.
  - Output: nxt[WIDTH].
  - Instantiated once by the controller.

## Test plan
- Rule 170, seed 64'h8000_0000_0000_0001, steps=1:
  - wrap=1: state 64'h0000_0000_0000_0003 and done one cycle later.
  - wrap=0: state 64'h0000_0000_0000_0002.
- Rule 90, seed 64'h1, wrap=1, steps=1 -> state 64'h8000_0000_0000_0002. Then steps=0 with start -> state reloads to 64'h1 and done pulses the next cycle.
- Rule 204, seed 64'h0123_4567_89AB_CDEF, steps=10 -> state unchanged, gen_count=10, busy high for 10 cycles, done pulse at cycle 11. Sweeping select 0..3 gives led CDEF, 89AB, 4567, 0123.
- Rule 0, steps=3, pause high for 2 cycles after the first step:
  - state=0 after step 1.
  - gen_count holds at 1 during the pause.
  - done 6 cycles after start.
- Start pulsed during RUN with a different seed -> ignored; the final state matches the undisturbed run.
- rst asserted mid-run with steps=50 -> next cycle state=0, gen_count=0, busy=0, and no done pulse.

Source files
------------

// File: rtl/ca_pkg.sv
// Shared types and constants for the cellular-automaton run controller.
package ca_pkg;

  localparam int unsigned CA_WIDTH = 64;
  localparam int unsigned CA_CNT_W = 8;

  localparam logic [7:0] RULE_IDENT = 8'd204;
  localparam logic [7:0] RULE_SHL   = 8'd170;
  localparam logic [7:0] RULE_90    = 8'd90;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } ca_state_t;

endpackage

// File: rtl/ca_next_gen.sv
// Combinational next-generation function of an elementary CA under an 8-bit Wolfram rule.
module ca_next_gen
  import ca_pkg::*;
#(
  parameter int unsigned WIDTH = CA_WIDTH
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [7:0]       rule,
  input  logic             wrap,
  output logic [WIDTH-1:0] nxt
);

  // Padded copy: ext[0] is the cell right of bit 0, ext[WIDTH+1] the cell left of bit WIDTH-1.
  logic [WIDTH+1:0] ext;

  assign ext = {wrap & cur[0], cur, wrap & cur[WIDTH-1]};

  always_comb begin
    nxt = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      nxt[i] = rule[ext[i+2 -: 3]];
    end
  end

endmodule

// File: rtl/ca_run_controller.sv
// Seed load / run / pause sequencer for the CA state register, with LED slice output.
module ca_run_controller
  import ca_pkg::*;
#(
  parameter int unsigned WIDTH = CA_WIDTH,
  parameter int unsigned CNT_W = CA_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic [7:0]       rule,
  input  logic [CNT_W-1:0] steps,
  input  logic             wrap,
  input  logic [WIDTH-1:0] seed,
  input  logic [1:0]       select,
  output logic [WIDTH-1:0] state,
  output logic [15:0]      led,
  output logic [CNT_W-1:0] gen_count,
  output logic             busy,
  output logic             done
);

  localparam int unsigned IDX_W = $clog2(WIDTH);

  ca_state_t        fsm, fsm_nxt;
  logic [7:0]       rule_q;
  logic [CNT_W-1:0] steps_q;
  logic             wrap_q;
  logic [WIDTH-1:0] nxt;
  logic [CNT_W-1:0] gen_inc;
  logic [IDX_W-1:0] led_base;

  ca_next_gen #(
    .WIDTH(WIDTH)
  ) u_next_gen (
    .cur (state),
    .rule(rule_q),
    .wrap(wrap_q),
    .nxt (nxt)
  );

  assign gen_inc = gen_count + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) fsm <= ST_IDLE;
    else     fsm <= fsm_nxt;
  end

  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      ST_IDLE: if (start) fsm_nxt = (steps != '0) ? ST_RUN : ST_DONE;
      ST_RUN:  if (!pause && gen_inc == steps_q) fsm_nxt = ST_DONE;
      ST_DONE: fsm_nxt = ST_IDLE;
      default: fsm_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= '0;
      gen_count <= '0;
      rule_q    <= '0;
      steps_q   <= '0;
      wrap_q    <= 1'b0;
    end else begin
      case (fsm)
        ST_IDLE: begin
          if (start) begin
            rule_q    <= rule;
            steps_q   <= steps;
            wrap_q    <= wrap;
            state     <= seed;
            gen_count <= '0;
          end
        end
        ST_RUN: begin
          if (!pause) begin
            state     <= nxt;
            gen_count <= gen_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (fsm == ST_RUN);
  assign done = (fsm == ST_DONE);

  assign led_base = IDX_W'({select, 4'b0000});
  assign led      = state[led_base +: 16];

endmodule

// File: tb/tb_ca_run_controller.sv
// Self-checking bench for ca_run_controller against a cycle-level behavioural model.
module tb_ca_run_controller;
  import ca_pkg::*;

  localparam int unsigned W  = 64;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst, start, pause, wrap;
  logic [7:0]    rule;
  logic [CW-1:0] steps;
  logic [W-1:0]  seed;
  logic [1:0]    select;
  logic [W-1:0]  state;
  logic [15:0]   led;
  logic [CW-1:0] gen_count;
  logic          busy, done;

  int checks = 0;
  int failures = 0;

  ca_run_controller #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .rule(rule),
    .steps(steps), .wrap(wrap), .seed(seed), .select(select),
    .state(state), .led(led), .gen_count(gen_count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference next generation: look up each cell's 3-cell neighbourhood value in the rule.
  function automatic logic [63:0] ref_next(input logic [63:0] s, input logic [7:0] r, input logic wr);
    logic [63:0] o;
    int l, c, rr;
    o = '0;
    for (int i = 0; i < 64; i++) begin
      l  = (i == 63) ? (wr ? int'(s[0]) : 0) : int'(s[i+1]);
      c  = int'(s[i]);
      rr = (i == 0) ? (wr ? int'(s[63]) : 0) : int'(s[i-1]);
      o[i] = r[4*l + 2*c + rr];
    end
    return o;
  endfunction

  function automatic logic [15:0] slice16(input logic [63:0] s, input logic [1:0] sel);
    return 16'((s >> (16 * int'(sel))) & 64'hFFFF);
  endfunction

  // One full run: start, per-cycle checks through DONE, then back in IDLE.
  task automatic run_case(input logic [63:0] sd, input logic [7:0] rl, input logic [7:0] st,
                          input logic wr, input logic [31:0] pmask, input int pct,
                          input bit disturb, output logic [63:0] fin);
    logic [63:0] exp_s;
    int k, cyc, limit;
    @(negedge clk);
    seed = sd; rule = rl; steps = st; wrap = wr; start = 1'b1; pause = 1'b0;
    @(posedge clk); #1;
    exp_s = sd; k = 0;
    check_eq("load_state", state, exp_s);
    check_eq("load_gen", 64'(gen_count), 64'd0);
    check_eq("load_busy", 64'(busy), 64'(st != 0));
    check_eq("load_done", 64'(done), 64'(st == 0));
    @(negedge clk);
    start = 1'b0;
    seed = {$urandom, $urandom}; rule = 8'($urandom); steps = 8'($urandom); wrap = 1'($urandom);
    cyc = 0;
    limit = 4 * int'(st) + 40;
    while (k < int'(st) && cyc < limit) begin
      pause  = ((cyc < 32) && pmask[cyc]) || ($urandom_range(99) < pct);
      select = 2'($urandom);
      if (disturb) start = 1'($urandom);
      @(posedge clk); #1;
      if (!pause) begin
        exp_s = ref_next(exp_s, rl, wr);
        k++;
      end
      check_eq("run_state", state, exp_s);
      check_eq("run_gen", 64'(gen_count), 64'(k));
      check_eq("run_busy", 64'(busy), 64'(k < int'(st)));
      check_eq("run_done", 64'(done), 64'(k == int'(st)));
      check_eq("run_led", 64'(led), 64'(slice16(exp_s, select)));
      cyc++;
      @(negedge clk);
    end
    start = 1'b0; pause = 1'b0;
    if (k < int'(st)) check_eq("run_timeout", 64'(k), 64'(st));
    @(posedge clk); #1;
    check_eq("idle_done", 64'(done), 64'd0);
    check_eq("idle_busy", 64'(busy), 64'd0);
    check_eq("idle_state", state, exp_s);
    check_eq("idle_gen", 64'(gen_count), 64'(st));
    fin = exp_s;
  endtask

  initial begin
    logic [63:0] fin;
    rst = 1'b1; start = 1'b0; pause = 1'b0; rule = '0; steps = '0; wrap = 1'b0;
    seed = '0; select = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_state", state, 64'd0);
    check_eq("rst_gen", 64'(gen_count), 64'd0);
    check_eq("rst_led", 64'(led), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    @(negedge clk); rst = 1'b0;

    run_case(64'h8000_0000_0000_0001, RULE_SHL, 8'd1, 1'b1, 32'd0, 0, 1'b0, fin);
    check_eq("shl_wrap", fin, 64'h0000_0000_0000_0003);
    run_case(64'h8000_0000_0000_0001, RULE_SHL, 8'd1, 1'b0, 32'd0, 0, 1'b0, fin);
    check_eq("shl_nowrap", fin, 64'h0000_0000_0000_0002);
    run_case(64'h1, RULE_90, 8'd1, 1'b1, 32'd0, 0, 1'b0, fin);
    check_eq("r90_wrap", fin, 64'h8000_0000_0000_0002);
    run_case(64'h1, RULE_90, 8'd0, 1'b1, 32'd0, 0, 1'b0, fin);
    check_eq("steps0_reload", fin, 64'h1);

    run_case(64'h0123_4567_89AB_CDEF, RULE_IDENT, 8'd10, 1'b0, 32'd0, 0, 1'b0, fin);
    check_eq("ident_state", fin, 64'h0123_4567_89AB_CDEF);
    for (int unsigned s = 0; s < 4; s++) begin
      @(negedge clk); select = 2'(s); #1;
      check_eq("led_sweep", 64'(led), 64'(slice16(64'h0123_4567_89AB_CDEF, 2'(s))));
    end
    check_eq("led_sel3", 64'(led), 64'h0123);

    // Rule 0 with two pause cycles after the first generation.
    run_case(64'hDEAD_BEEF_0000_FFFF, 8'd0, 8'd3, 1'b1, 32'b110, 0, 1'b0, fin);
    check_eq("rule0_state", fin, 64'd0);

    // Start pulses and input changes during RUN must not disturb the run.
    run_case(64'hA5A5_0F0F_3C3C_9999, 8'd30, 8'd12, 1'b1, 32'd0, 0, 1'b1, fin);
    check_eq("disturb_final", fin,
             ref_next(ref_next(ref_next(ref_next(ref_next(ref_next(ref_next(ref_next(
               ref_next(ref_next(ref_next(ref_next(64'hA5A5_0F0F_3C3C_9999,
               8'd30,1),8'd30,1),8'd30,1),8'd30,1),8'd30,1),8'd30,1),8'd30,1),8'd30,1),
               8'd30,1),8'd30,1),8'd30,1),8'd30,1));

    for (int n = 0; n < 20; n++) begin
      run_case({$urandom, $urandom}, 8'($urandom), 8'($urandom_range(0, 20)),
               1'($urandom), 32'd0, 20, 1'b1, fin);
    end

    // Reset in the middle of a long run aborts without a done pulse.
    @(negedge clk);
    seed = 64'hFFFF_0000_FFFF_0000; rule = RULE_90; steps = 8'd50; wrap = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("abort_state", state, 64'd0);
    check_eq("abort_gen", 64'(gen_count), 64'd0);
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_done", 64'(done), 64'd0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_eq("abort_nodone", 64'(done), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
